// File: rtl/onehot2bin_serializer.sv
// -----------------------------------------------------------------------------
// onehot2bin_serializer
//
// Captures a one-hot (or multi-hot) request vector and serializes its set bits
// as binary indices, lowest index first, under a valid/ready handshake.
//
// Two-state machine:
//   IDLE  - waits for enable=1 with a non-zero req_in, then loads the pending
//           vector and moves to SERVE.
//   SERVE - offers the lowest pending index. Each accepted beat clears that bit.
//           The last accepted beat returns the machine to IDLE.
//           req_in and enable are ignored in this state.
//
// The outputs are decoded only from registered state and the pending vector.
// There is no combinational path from req_in to any output.
//
// Configuration:
//   ONEHOT_STRICT_EN - strict one-hot mode. A captured vector with more than one
//                      bit set raises the sticky err_multi flag. Only the lowest
//                      set bit is loaded. When undefined, every set bit is served
//                      in ascending order and err_multi is tied to 0.
//
// Parameters:
//   k          binary index width; N = 2**k request lines
//
// Ports:
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   enable     capture qualifier (used only in IDLE)
//   req_in     [N-1:0] request vector; bit i requests index i
//   ready_in   downstream accepts idx_out when valid_out is also high
//   idx_out    [k-1:0] index currently offered
//   valid_out  idx_out holds a valid index
//   busy       captured vector still has unserved bits (state == SERVE)
//   err_multi  sticky multi-hot capture flag (strict mode only)
// -----------------------------------------------------------------------------
module onehot2bin_serializer #(
  parameter  int k = 6,
  localparam int N = 2**k
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req_in,
  input  logic         ready_in,
  output logic [k-1:0] idx_out,
  output logic         valid_out,
  output logic         busy,
  output logic         err_multi
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state, state_nxt;
  logic [N-1:0] pend, pend_nxt;
  logic [N-1:0] load_vec;

  // x & (x - 1) clears the lowest set bit. It is used to retire the bit just served.
`ifdef ONEHOT_STRICT_EN
  logic err_q, err_nxt;
  logic multi_hot;

  // Keep only the lowest set bit of the request vector.
  assign load_vec  = req_in & (~req_in + ONE);
  assign multi_hot = (req_in & (req_in - ONE)) != '0;
  assign err_multi = err_q;
`else
  assign load_vec  = req_in;
  assign err_multi = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

`ifdef ONEHOT_STRICT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_nxt;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. A path that does not
  // assign a signal would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
`ifdef ONEHOT_STRICT_EN
    err_nxt   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (enable && (req_in != '0)) begin
          state_nxt = SERVE;
          pend_nxt  = load_vec;
`ifdef ONEHOT_STRICT_EN
          if (multi_hot) err_nxt = 1'b1;
`endif
        end
      end
      SERVE: begin
        // valid_out is always high in SERVE. A ready beat is therefore an
        // accepted transfer.
        if (ready_in) begin
          pend_nxt = pend & (pend - ONE);
          if ((pend & (pend - ONE)) == '0) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Priority encoder for the lowest set bit. The loop runs from the top down,
  // so the lowest index is the last assignment and wins.
  always_comb begin
    idx_out   = '0;
    valid_out = 1'b0;
    busy      = 1'b0;
    if (state == SERVE) begin
      valid_out = 1'b1;
      busy      = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) idx_out = k'(i);
      end
    end
  end

endmodule

// File: tb/tb_onehot2bin_serializer.sv
// -----------------------------------------------------------------------------
// tb_onehot2bin_serializer
//
// Self-checking bench for onehot2bin_serializer with k = 6 (64 request lines).
// A table of directed capture vectors is applied, and each vector is checked
// against its hand-computed index sequence. Hand-written sequences then cover
// the following multi-cycle corners:
//   - stall under ready_in = 0
//   - recapture timing after a return to IDLE
//   - requests arriving during SERVE (must be ignored)
//   - mid-SERVE asynchronous reset
//   - long enable-low windows
// Define ONEHOT_STRICT_EN for the strict-mode variant of the expectations.
// -----------------------------------------------------------------------------
module tb_onehot2bin_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] req_in;
  logic        ready_in;
  logic [5:0]  idx_out;
  logic        valid_out;
  logic        busy;
  logic        err_multi;

  int total = 0;
  int bad   = 0;
  logic exp_err = 1'b0;

  onehot2bin_serializer #(.k(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_in    (req_in),
    .ready_in  (ready_in),
    .idx_out   (idx_out),
    .valid_out (valid_out),
    .busy      (busy),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            en;
    logic [63:0]     req;
    int              n;       // number of indices served in non-strict mode
    logic [3:0][5:0] idx;     // expected indices; idx[0] is offered first
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [63:0] req, input int n,
                              input logic [5:0] a, input logic [5:0] b,
                              input logic [5:0] c, input logic [5:0] d);
    vec_t v;
    v.en = en; v.req = req; v.n = n;
    v.idx[0] = a; v.idx[1] = b; v.idx[2] = c; v.idx[3] = d;
    return v;
  endfunction

  // Applies one table vector with ready_in held high and walks through the
  // expected serve sequence. All checks are made on the falling edge.
  task automatic run_vec(input vec_t v, input int num);
    int n_eff;
    n_eff = v.n;
`ifdef ONEHOT_STRICT_EN
    if (v.n > 1) exp_err = 1'b1;
    if (v.n > 1) n_eff = 1;
`endif
    @(negedge clk);
    enable = v.en; req_in = v.req; ready_in = 1'b1;
    @(negedge clk);
    enable = 1'b0; req_in = '0;
    for (int j = 0; j < n_eff; j++) begin
      check($sformatf("vec%0d beat%0d valid", num, j), 64'(valid_out), 64'd1);
      check($sformatf("vec%0d beat%0d idx", num, j), 64'(idx_out), 64'(v.idx[j]));
      check($sformatf("vec%0d beat%0d busy", num, j), 64'(busy), 64'd1);
      if (j == 0) check($sformatf("vec%0d err_multi", num), 64'(err_multi), 64'(exp_err));
      @(negedge clk);
    end
    check($sformatf("vec%0d end valid", num), 64'(valid_out), 64'd0);
    check($sformatf("vec%0d end busy", num), 64'(busy), 64'd0);
    check($sformatf("vec%0d end idx", num), 64'(idx_out), 64'd0);
  endtask

  initial begin
    logic [63:0] v_b3_9, v_b0_5_63;
    v_b3_9    = (64'd1 << 3) | (64'd1 << 9);
    v_b0_5_63 = 64'd1 | (64'd1 << 5) | (64'd1 << 63);

    vecs[0] = mk(1'b1, 64'd1 << 37, 1, 6'd37, 6'd0, 6'd0, 6'd0);
    vecs[1] = mk(1'b1, v_b0_5_63, 3, 6'd0, 6'd5, 6'd63, 6'd0);
    vecs[2] = mk(1'b1, 64'd1, 1, 6'd0, 6'd0, 6'd0, 6'd0);
    vecs[3] = mk(1'b1, 64'd1 << 63, 1, 6'd63, 6'd0, 6'd0, 6'd0);
    vecs[4] = mk(1'b1, 64'h0000_0000_0000_3C00, 4, 6'd10, 6'd11, 6'd12, 6'd13);
    vecs[5] = mk(1'b0, '1, 0, 6'd0, 6'd0, 6'd0, 6'd0);
    vecs[6] = mk(1'b1, '0, 0, 6'd0, 6'd0, 6'd0, 6'd0);

    rst_n = 1'b0; enable = 1'b0; req_in = '0; ready_in = 1'b0;
    #12;
    check("reset valid", 64'(valid_out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset idx", 64'(idx_out), 64'd0);
    check("reset err", 64'(err_multi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Multi-hot capture with ready_in low for 4 cycles, then back-to-back serving.
    @(negedge clk);
    enable = 1'b1; req_in = v_b0_5_63; ready_in = 1'b0;
    @(negedge clk);
    enable = 1'b0; req_in = '0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("stall%0d idx", j), 64'(idx_out), 64'd0);
      check($sformatf("stall%0d valid", j), 64'(valid_out), 64'd1);
      if (j < 3) @(negedge clk);
    end
    ready_in = 1'b1;
    @(negedge clk);
`ifdef ONEHOT_STRICT_EN
    check("stall strict done", 64'(valid_out), 64'd0);
`else
    check("stall idx5", 64'(idx_out), 64'd5);
    check("stall valid5", 64'(valid_out), 64'd1);
    @(negedge clk);
    check("stall idx63", 64'(idx_out), 64'd63);
    check("stall valid63", 64'(valid_out), 64'd1);
    @(negedge clk);
    check("stall done", 64'(valid_out), 64'd0);
`endif

    // Recapture is not allowed before the IDLE cycle, even with enable held high.
    @(negedge clk);
    enable = 1'b1; req_in = 64'd1 << 3; ready_in = 1'b1;
    @(negedge clk);
    req_in = 64'd1 << 7;
    check("recap first idx", 64'(idx_out), 64'd3);
    @(negedge clk);
    check("recap idle gap", 64'(valid_out), 64'd0);
    @(negedge clk);
    enable = 1'b0; req_in = '0;
    check("recap second idx", 64'(idx_out), 64'd7);
    check("recap second valid", 64'(valid_out), 64'd1);
    @(negedge clk);
    check("recap end", 64'(valid_out), 64'd0);

    // Requests that arrive during SERVE are neither merged nor allowed to abort.
    @(negedge clk);
    enable = 1'b1; req_in = (64'd1 << 2) | (64'd1 << 4); ready_in = 1'b0;
`ifdef ONEHOT_STRICT_EN
    exp_err = 1'b1;
`endif
    @(negedge clk);
    req_in = 64'd1 << 1;
    @(negedge clk);
    check("ignore hold idx", 64'(idx_out), 64'd2);
    enable = 1'b0; req_in = '0; ready_in = 1'b1;
    @(negedge clk);
`ifdef ONEHOT_STRICT_EN
    check("ignore strict done", 64'(valid_out), 64'd0);
`else
    check("ignore next idx", 64'(idx_out), 64'd4);
    @(negedge clk);
    check("ignore done", 64'(valid_out), 64'd0);
`endif
    check("err before reset", 64'(err_multi), 64'(exp_err));

    // Reset pulsed low between clock edges during SERVE.
    @(negedge clk);
    enable = 1'b1; req_in = (64'd1 << 1) | (64'd1 << 2); ready_in = 1'b0;
    @(negedge clk);
    enable = 1'b0; req_in = '0;
    check("rst pre idx", 64'(idx_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check("rst async valid", 64'(valid_out), 64'd0);
    check("rst async busy", 64'(busy), 64'd0);
    check("rst async idx", 64'(idx_out), 64'd0);
    check("rst async err", 64'(err_multi), 64'd0);
    #1 rst_n = 1'b1;
    ready_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("rst post%0d valid", j), 64'(valid_out), 64'd0);
    end

    // A long enable-low window with every request line set causes no capture.
    enable = 1'b0; req_in = '1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("en_low%0d valid", j), 64'(valid_out), 64'd0);
    end
    req_in = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot2bin_serializer.md
ONEHOT2BIN_SERIALIZER -- requirements
Module: onehot2bin_serializer

Interface
REQ-001 The block SHALL have parameter k, default 6, meaning binary index width; N = 2**k request lines.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 enable  input  1  capture qualifier; a request vector is sampled only when high.
REQ-005 req_in  input  N  one-hot (or multi-hot) request vector; bit i requests index i.
REQ-006 ready_in  input  1  downstream accepts idx_out on a cycle where valid_out and ready_in are both high.
REQ-007 idx_out  output  k  binary index of the currently offered request.
REQ-008 valid_out  output  1  idx_out holds a valid index.
REQ-009 busy  output  1  high while a captured vector still has unserved bits.
REQ-010 err_multi  output  1  sticky flag: a captured vector had more than one bit set (strict mode only).

Function
REQ-011 The block SHALL be a two-state machine, IDLE and SERVE, with a registered pending vector pend[N-1:0].
REQ-012 In IDLE, on a rising edge with enable=1 and req_in != 0, the block SHALL load pend from req_in and enter SERVE.
REQ-013 In IDLE with enable=0 or req_in == 0, the block SHALL remain in IDLE with pend unchanged at 0.
REQ-014 In SERVE, idx_out SHALL equal the lowest index i with pend[i]=1, and valid_out SHALL be 1.
REQ-015 Latency: valid_out SHALL rise on the first edge after the capture edge (1 cycle); no combinational path from req_in to outputs.
REQ-016 While valid_out=1 and ready_in=0, idx_out and pend SHALL hold stable.
REQ-017 On valid_out=1 and ready_in=1, the served bit SHALL be cleared in pend at that edge; if bits remain, the next-lowest index SHALL be offered the following cycle with valid_out held high (no bubble).
REQ-018 On acceptance of the last pending bit, the block SHALL return to IDLE; valid_out SHALL be 0 the next cycle; a new capture SHALL occur no earlier than that IDLE cycle.
REQ-019 req_in and enable SHALL be ignored in SERVE; no abort or merge of new requests.
REQ-020 Index N-1 (bit MSB) SHALL encode as all-ones on idx_out; index 0 SHALL encode as 0.
REQ-021 busy SHALL equal (state == SERVE); in IDLE, valid_out=0 and idx_out=0.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, pend=0, idx_out=0, valid_out=0, busy=0, err_multi=0, independent of clk.
REQ-023 Reset asserted mid-SERVE SHALL discard all pending bits; no index is offered after deassertion until a new capture.
REQ-024 Deassertion SHALL take effect at the first rising clk edge with rst_n=1.

Configuration
REQ-025 Macro ONEHOT_STRICT_EN SHALL select strict one-hot mode.
REQ-026 With ONEHOT_STRICT_EN defined: a captured vector with popcount > 1 SHALL set err_multi (sticky until reset) and pend SHALL be loaded with only its lowest set bit.
REQ-027 Without ONEHOT_STRICT_EN: all set bits are loaded and served in ascending order; err_multi SHALL be tied 0.

Verification
REQ-028 k=6, enable=1, req_in=1<<37, ready_in=1 -> next cycle idx_out=37, valid_out=1; following cycle valid_out=0, busy=0.
REQ-029 req_in=bits{0,5,63}, ready_in=1 (non-strict) -> idx_out 0,5,63 on three consecutive cycles with valid_out high, then IDLE; err_multi=0.
REQ-030 Same vector, ready_in=0 for 4 cycles then 1 -> idx_out=0 stable 4 cycles, then 5, 63 on back-to-back cycles.
REQ-031 ONEHOT_STRICT_EN defined, req_in=bits{3,9} -> idx_out=3 once, err_multi=1 from next cycle, stays 1 through later one-hot captures until rst_n=0.
REQ-032 rst_n pulsed low between clock edges during SERVE of bits{1,2} -> valid_out=0, busy=0 immediately; after release with enable=0, valid_out stays 0.
REQ-033 enable=0 with req_in=all-ones for 10 cycles -> valid_out stays 0; also req_in=0 with enable=1 -> no capture.
